mul_issue_ctrl: RTL

Initiator-side controller for the pipeline's 64-bit integer multiply unit. It sits between the issue stage and the multiplier.
- Accepts one RV64M multiply op via a valid/ready handshake.
- Drives the multiplier's request/kill/operand interface and holds every operand field stable until done.
- Captures the result, sign-extends MULW results, and presents a tagged writeback with backpressure.
- Propagates pipeline flushes as multiplier kills.

---
 rtl/mul_issue_ctrl_if.sv | 46 ++++
 rtl/mul_issue_ctrl.sv | 111 +++++++++++
 2 files changed

// File: rtl/mul_issue_ctrl_if.sv
// Handshake bundle between the issue stage, the multiply unit and writeback.
// Signal suffixes give the direction as seen from the controller.
interface mul_issue_ctrl_if #(
  parameter int TAG_W = 6
);
  logic             flush_i;
  logic             issue_valid_i;
  logic             issue_ready_o;
  logic [2:0]       issue_func3_i;
  logic             issue_w_i;
  logic [63:0]      issue_src1_i;
  logic [63:0]      issue_src2_i;
  logic [4:0]       issue_rd_i;
  logic [TAG_W-1:0] issue_tag_i;
  logic             mul_request_o;
  logic             mul_kill_o;
  logic [2:0]       mul_func3_o;
  logic             mul_int32_o;
  logic [63:0]      mul_src1_o;
  logic [63:0]      mul_src2_o;
  logic             mul_stall_i;
  logic             mul_done_i;
  logic [63:0]      mul_result_i;
  logic             wb_valid_o;
  logic             wb_ready_i;
  logic [4:0]       wb_rd_o;
  logic [TAG_W-1:0] wb_tag_o;
  logic [63:0]      wb_data_o;
  logic             err_o;

  // Controller side.
  modport slave (
    input  flush_i, issue_valid_i, issue_func3_i, issue_w_i, issue_src1_i, issue_src2_i,
           issue_rd_i, issue_tag_i, mul_stall_i, mul_done_i, mul_result_i, wb_ready_i,
    output issue_ready_o, mul_request_o, mul_kill_o, mul_func3_o, mul_int32_o,
           mul_src1_o, mul_src2_o, wb_valid_o, wb_rd_o, wb_tag_o, wb_data_o, err_o
  );

  // Environment side: issue stage, multiplier and writeback sink.
  modport master (
    output flush_i, issue_valid_i, issue_func3_i, issue_w_i, issue_src1_i, issue_src2_i,
           issue_rd_i, issue_tag_i, mul_stall_i, mul_done_i, mul_result_i, wb_ready_i,
    input  issue_ready_o, mul_request_o, mul_kill_o, mul_func3_o, mul_int32_o,
           mul_src1_o, mul_src2_o, wb_valid_o, wb_rd_o, wb_tag_o, wb_data_o, err_o
  );
endinterface

// File: rtl/mul_issue_ctrl.sv
// Issue-side controller for the 64-bit multiply unit: accepts one op, sequences
// request/done with the multiplier and returns a tagged, backpressured writeback.
module mul_issue_ctrl #(
  parameter int TAG_W   = 6,
  parameter int TIMEOUT = 8
) (
  input logic             clk_i,
  input logic             rst_ni,
  mul_issue_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_WB} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [2:0]       func3_q;
  logic             int32_q;
  logic [63:0]      src1_q, src2_q, data_q;
  logic [4:0]       rd_q;
  logic [TAG_W-1:0] tag_q;

  logic             accept, in_flight, timeout_hit, capture;
  logic [63:0]      result_ext;

  assign bus.issue_ready_o = (state_q == S_IDLE) & ~bus.flush_i;
  assign accept            = bus.issue_valid_i & bus.issue_ready_o;
  assign in_flight         = (state_q == S_REQ) | (state_q == S_WAIT);
  // The WAIT cycle with count TIMEOUT-1 is the last one allowed; kill is raised in that cycle.
  assign timeout_hit = (state_q == S_WAIT) & ~bus.mul_done_i & ~bus.flush_i &
                       (cnt_q == CNT_W'(TIMEOUT - 1));
  assign capture     = (state_q == S_WAIT) & bus.mul_done_i & ~bus.flush_i;
  assign result_ext  = int32_q ? {{32{bus.mul_result_i[31]}}, bus.mul_result_i[31:0]}
                               : bus.mul_result_i;

  assign bus.mul_request_o = (state_q == S_REQ) & ~bus.flush_i;
  assign bus.mul_kill_o    = (bus.flush_i & in_flight) | timeout_hit;
  assign bus.mul_func3_o   = func3_q;
  assign bus.mul_int32_o   = int32_q;
  assign bus.mul_src1_o    = src1_q;
  assign bus.mul_src2_o    = src2_q;
  assign bus.wb_valid_o    = (state_q == S_WB);
  assign bus.wb_rd_o       = rd_q;
  assign bus.wb_tag_o      = tag_q;
  assign bus.wb_data_o     = data_q;
  assign bus.err_o         = err_q;

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = S_REQ;
      S_REQ: begin
        cnt_d   = '0;
        state_d = bus.flush_i ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus.flush_i) begin
          state_d = S_IDLE;
        end else if (bus.mul_done_i) begin
          state_d = S_WB;
        end else if (timeout_hit) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
      end
      S_WB: if (bus.flush_i || bus.wb_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // NOTE: datapath registers are reset as well, so operand and writeback outputs read 0 out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      func3_q <= '0;
      int32_q <= 1'b0;
      src1_q  <= '0;
      src2_q  <= '0;
      rd_q    <= '0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      if (accept) begin
        func3_q <= bus.issue_func3_i;
        int32_q <= bus.issue_w_i & (bus.issue_func3_i == 3'b000);
        src1_q  <= bus.issue_src1_i;
        src2_q  <= bus.issue_src2_i;
        rd_q    <= bus.issue_rd_i;
        tag_q   <= bus.issue_tag_i;
      end
      if (capture) data_q <= result_ext;
    end
  end
endmodule
